// File: rtl/irq_pkg.sv
// Shared constants and types for the 8-channel interrupt pending controller.
package irq_pkg;

  localparam int unsigned N_CH  = 8;
  localparam int unsigned IDX_W = 3;

  typedef enum logic {ST_IDLE, ST_OFFER} irq_state_t;

endpackage

// File: rtl/pri_enc8_3.sv
// Fixed-priority 8:3 encoder; bit 7 has the highest priority.
module pri_enc8_3
  import irq_pkg::*;
(
  input  logic [N_CH-1:0]  vec_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  always_comb begin
    idx_o = '0;
    // Ascending scan: the last (highest) set bit wins.
    for (int i = 0; i < N_CH; i++) begin
      if (vec_i[i]) idx_o = IDX_W'(i);
    end
    any_o = |vec_i;
  end

endmodule

// File: rtl/irq_pend_ctrl8.sv
// Synchronises eight request lines, latches events as pending and offers the
// highest-priority unmasked pending channel over a valid/ready handshake.
module irq_pend_ctrl8
  import irq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          EDGE_MODE   = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_CH-1:0]  irq_in,
  input  logic [N_CH-1:0]  mask,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx,
  input  logic             out_ready,
  output logic [N_CH-1:0]  pending,
  output logic             overflow
);

  logic [N_CH-1:0] evt_vec;

  // Per-channel synchroniser, edge-detect flop and registered event stage.
  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    logic [SYNC_STAGES-1:0] chain_q, chain_d;
    logic                   dly_q, dly_d;
    logic                   evt_q, evt_d;
    logic                   s;

    assign s = chain_q[SYNC_STAGES-1];

    always_comb begin
      chain_d = {chain_q[SYNC_STAGES-2:0], irq_in[ch]};
      dly_d   = s;
      evt_d   = EDGE_MODE ? (s & ~dly_q) : s;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        chain_q <= '0;
        dly_q   <= 1'b0;
        evt_q   <= 1'b0;
      end else begin
        chain_q <= chain_d;
        dly_q   <= dly_d;
        evt_q   <= evt_d;
      end
    end

    assign evt_vec[ch] = evt_q;
  end

  logic [N_CH-1:0]  pending_q, pending_d;
  logic             overflow_q, overflow_d;
  irq_state_t       state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [IDX_W-1:0] out_idx_q, out_idx_d;

  logic [N_CH-1:0]  set_vec, clear_vec;
  logic [IDX_W-1:0] enc_idx;
  logic             enc_any;

  pri_enc8_3 u_pri_enc (
    .vec_i (pending_q & mask),
    .idx_o (enc_idx),
    .any_o (enc_any)
  );

  always_comb begin
    set_vec   = en ? evt_vec : '0;
    clear_vec = '0;
    if (out_valid_q && out_ready) clear_vec[out_idx_q] = 1'b1;
    // A set landing on the bit being cleared wins, so the new event survives.
    pending_d  = set_vec | (pending_q & ~clear_vec);
    overflow_d = |(set_vec & pending_q & ~clear_vec);
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    unique case (state_q)
      ST_IDLE: begin
        if (en && enc_any) begin
          out_idx_d   = enc_idx;
          out_valid_d = 1'b1;
          state_d     = ST_OFFER;
        end
      end
      ST_OFFER: begin
        // The offer is frozen until accepted, regardless of en, mask or new arrivals.
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q   <= '0;
      overflow_q  <= 1'b0;
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
    end else begin
      pending_q   <= pending_d;
      overflow_q  <= overflow_d;
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign pending   = pending_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_irq_pend_ctrl8.sv
// Directed and randomized checks of irq_pend_ctrl8 against a delay-line reference model.
module tb_irq_pend_ctrl8;

  localparam int unsigned S    = 2;
  localparam bit          EDGE = 1'b1;

  logic       clk = 1'b0;
  logic       rst, en, out_ready;
  logic [7:0] irq_in, mask;
  logic       out_valid, overflow;
  logic [2:0] out_idx;
  logic [7:0] pending;

  always #5 clk = ~clk;

  irq_pend_ctrl8 #(
    .SYNC_STAGES (S),
    .EDGE_MODE   (EDGE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .irq_in    (irq_in),
    .mask      (mask),
    .out_valid (out_valid),
    .out_idx   (out_idx),
    .out_ready (out_ready),
    .pending   (pending),
    .overflow  (overflow)
  );

  int n_chk = 0;
  int n_bad = 0;

  // Reference state: raw-sample history (index 0 = newest) and architectural outputs.
  logic [7:0] m_hist [S+2];
  logic [7:0] m_pend;
  logic       m_valid, m_ovf;
  logic [2:0] m_idx;
  int         acc_q[$];
  int         ovf_seen;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [2:0] highest(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) if (v[i]) return 3'(i);
    return 3'd0;
  endfunction

  task automatic model_edge();
    logic [7:0] evt, set, clr, elig;
    if (rst) begin
      for (int j = 0; j < S + 2; j++) m_hist[j] = 8'h00;
      m_pend = 8'h00; m_valid = 1'b0; m_idx = 3'd0; m_ovf = 1'b0;
      return;
    end
    // An event needs S synchroniser samples, one edge-detect sample and one event register.
    evt  = EDGE ? (m_hist[S] & ~m_hist[S+1]) : m_hist[S];
    set  = en ? evt : 8'h00;
    clr  = (m_valid && out_ready) ? (8'h01 << m_idx) : 8'h00;
    elig = m_pend & mask;
    m_ovf = |(set & m_pend & ~clr);
    if (m_valid) begin
      if (out_ready) m_valid = 1'b0;
    end else if (en && elig != 8'h00) begin
      m_idx   = highest(elig);
      m_valid = 1'b1;
    end
    m_pend = set | (m_pend & ~clr);
    for (int j = S + 1; j > 0; j--) m_hist[j] = m_hist[j-1];
    m_hist[0] = irq_in;
  endtask

  task automatic step();
    if (!rst && out_valid && out_ready) acc_q.push_back(int'(out_idx));
    @(posedge clk);
    model_edge();
    #1;
    chk("valid", {7'd0, out_valid}, {7'd0, m_valid});
    chk("idx", {5'd0, out_idx}, {5'd0, m_idx});
    chk("pend", pending, m_pend);
    chk("ovf", {7'd0, overflow}, {7'd0, m_ovf});
    if (overflow) ovf_seen++;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!out_valid && n < 20) begin step(); n++; end
    chk(tag, {7'd0, out_valid}, 8'd1);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; irq_in = 8'h00; mask = 8'hFF; out_ready = 1'b0;
    #1;
    // 1: reset and idle
    repeat (3) step();
    rst = 1'b0;
    repeat (10) step();
    chk("idle_valid", {7'd0, out_valid}, 8'd0);
    chk("idle_pend", pending, 8'h00);

    // 2: single edge on channel 5, offer at k+4
    irq_in = 8'h20; step();
    irq_in = 8'h00; repeat (3) step();
    chk("lat_early", {7'd0, out_valid}, 8'd0);
    step();
    chk("lat_valid", {7'd0, out_valid}, 8'd1);
    chk("lat_idx", {5'd0, out_idx}, 8'd5);
    out_ready = 1'b1; step();
    chk("acc_pend5", {7'd0, pending[5]}, 8'd0);
    chk("acc_valid", {7'd0, out_valid}, 8'd0);

    // 3: priority order 7, 3, 1
    acc_q.delete();
    irq_in = 8'h8A; step();
    irq_in = 8'h00; repeat (12) step();
    chk("pri_cnt", 8'(acc_q.size()), 8'd3);
    if (acc_q.size() == 3) begin
      chk("pri_0", 8'(acc_q[0]), 8'd7);
      chk("pri_1", 8'(acc_q[1]), 8'd3);
      chk("pri_2", 8'(acc_q[2]), 8'd1);
    end
    chk("pri_pend", pending, 8'h00);

    // 4: masking
    acc_q.delete();
    mask = 8'h7F; irq_in = 8'h81; step();
    irq_in = 8'h00; repeat (10) step();
    chk("msk_cnt", 8'(acc_q.size()), 8'd1);
    if (acc_q.size() == 1) chk("msk_idx", 8'(acc_q[0]), 8'd0);
    chk("msk_pend", pending, 8'h80);
    mask = 8'hFF; repeat (4) step();
    chk("msk_cnt2", 8'(acc_q.size()), 8'd2);
    if (acc_q.size() == 2) chk("msk_idx7", 8'(acc_q[1]), 8'd7);

    // 5: offer stability and overflow
    acc_q.delete();
    out_ready = 1'b0; irq_in = 8'h04; step();
    irq_in = 8'h00; wait_valid("stb_wait");
    chk("stb_idx0", {5'd0, out_idx}, 8'd2);
    ovf_seen = 0;
    irq_in = 8'h44; step();
    irq_in = 8'h00; repeat (6) step();
    chk("stb_idx1", {5'd0, out_idx}, 8'd2);
    chk("stb_ovf", 8'(ovf_seen), 8'd1);
    out_ready = 1'b1; repeat (3) step();
    chk("stb_acc", 8'(acc_q.size()), 8'd2);
    if (acc_q.size() == 2) begin
      chk("stb_first", 8'(acc_q[0]), 8'd2);
      chk("stb_next", 8'(acc_q[1]), 8'd6);
    end

    // 6: set/clear collision on channel 4
    out_ready = 1'b0; repeat (3) step();
    irq_in = 8'h10; step();
    irq_in = 8'h00; wait_valid("col_wait");
    chk("col_idx", {5'd0, out_idx}, 8'd4);
    irq_in = 8'h10; step();
    irq_in = 8'h00; step(); step();
    out_ready = 1'b1; step();
    chk("col_pend4", {7'd0, pending[4]}, 8'd1);
    chk("col_ovf", {7'd0, overflow}, 8'd0);
    chk("col_valid0", {7'd0, out_valid}, 8'd0);
    out_ready = 1'b0; step();
    chk("col_reoffer", {7'd0, out_valid}, 8'd1);
    chk("col_reidx", {5'd0, out_idx}, 8'd4);

    // Randomized traffic, including occasional mid-offer reset.
    for (int c = 0; c < 1500; c++) begin
      rst       = ($urandom_range(0, 199) == 0);
      en        = ($urandom_range(0, 9) != 0);
      irq_in    = 8'($urandom) & 8'($urandom) & 8'($urandom);
      mask      = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
      out_ready = ($urandom_range(0, 2) != 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
